uart_echo_responder: RTL and testbench

Hardware responder for the UART link: consumes bytes delivered by the `uart` receive side (`ready`/`data_out`/`ready_clr`) and retransmits each one through the `uart` transmit side (`data_in`/`wr_en`/`Tx_busy`). An optional XOR mask is applied before retransmission. A small FIFO decouples the two directions. It sits between the `uart` core and the rest of the fabric, and lets a host-side initiator run the same send-and-verify loop against real silicon.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_echo_responder_if.sv | 30 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_echo_responder.sv | 151 +++++++++++++++
 tb/tb_uart_echo_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART echo responder slice: the data width, the
// width of the echo counter, and the state encodings of the ingest and egress
// state machines.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int ECHO_W = 16;

  // Ingest side: take a byte, acknowledge it, then wait for the receiver
  // to drop its ready flag so the same byte is never pushed twice.
  typedef enum logic [1:0] {
    IN_IDLE,
    IN_CLR,
    IN_WAIT_LOW
  } in_state_t;

  // Egress side: pop, strobe the transmitter, then follow its busy flag.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_STROBE,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/uart_echo_responder_if.sv
// ---------------------------------------------------------------------------
// uart_echo_responder_if
// Handshake bundle between the uart core and the echo responder.
//   rx_ready / rx_data   : receiver holds a byte (core -> responder)
//   rx_ready_clr         : one-cycle acknowledge (responder -> core)
//   tx_busy              : transmitter busy (core -> responder)
//   tx_data / tx_wr_en   : byte to send and its write strobe (responder -> core)
// The master modport is the uart core side, the slave modport the responder.
// ---------------------------------------------------------------------------
interface uart_echo_responder_if;
  import uart_pkg::*;

  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready_clr;
  logic              tx_busy;
  logic [DATA_W-1:0] tx_data;
  logic              tx_wr_en;

  modport master (
    output rx_ready, rx_data, tx_busy,
    input  rx_ready_clr, tx_data, tx_wr_en
  );

  modport slave (
    input  rx_ready, rx_data, tx_busy,
    output rx_ready_clr, tx_data, tx_wr_en
  );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. dout always presents the head entry.
//   clk, rst_n : clock and synchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop, dout  : read request and head data (ignored when empty)
//   count      : number of entries held
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap on their own.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push against a full buffer
  // is still taken when a pop happens alongside it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
      else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_echo_responder.sv
// ---------------------------------------------------------------------------
// uart_echo_responder
// Takes every byte the uart receiver delivers, buffers it, and hands it back
// to the uart transmitter XORed with XOR_MASK, strictly in arrival order.
//   clk_50m    : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   uart       : rx/tx handshake bundle (slave side)
//   fifo_count : bytes currently buffered
//   overflow   : sticky, set when a byte arrives with the buffer full
//   echo_count : bytes handed to the transmitter, wraps around
// ---------------------------------------------------------------------------
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int                FIFO_DEPTH   = 4,
  parameter logic [DATA_W-1:0] XOR_MASK     = 8'h00,
  parameter int                BUSY_TIMEOUT = 4
) (
  input  logic                          clk_50m,
  input  logic                          rst_n,
  uart_echo_responder_if.slave          uart,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [ECHO_W-1:0]             echo_count
);

  localparam int                 TIMER_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  in_state_t          in_state, in_next;
  tx_state_t          tx_state, tx_next;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_dout;
  logic [TIMER_W-1:0] busy_timer;
  logic [DATA_W-1:0]  tx_data_q;
  logic               rx_ready_clr_c;
  logic               tx_wr_en_c;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (uart.rx_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State registers for both machines.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      in_state <= IN_IDLE;
      tx_state <= TX_IDLE;
    end else begin
      in_state <= in_next;
      tx_state <= tx_next;
    end
  end

  // Ingest: push on the first cycle ready is seen, acknowledge on the next,
  // then hold off until ready has dropped.
  always_comb begin
    in_next        = in_state;
    fifo_push      = 1'b0;
    rx_ready_clr_c = 1'b0;
    case (in_state)
      IN_IDLE: begin
        if (uart.rx_ready) begin
          fifo_push = 1'b1;
          in_next   = IN_CLR;
        end
      end
      IN_CLR: begin
        rx_ready_clr_c = 1'b1;
        in_next        = IN_WAIT_LOW;
      end
      IN_WAIT_LOW: begin
        if (!uart.rx_ready) in_next = IN_IDLE;
      end
      default: in_next = IN_IDLE;
    endcase
  end

  // Egress: pop when the transmitter is free, strobe for one cycle, then
  // track busy. A transmitter that never raises busy is given up on after
  // BUSY_TIMEOUT cycles so the echo path cannot stall.
  always_comb begin
    tx_next    = tx_state;
    fifo_pop   = 1'b0;
    tx_wr_en_c = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty && !uart.tx_busy) begin
          fifo_pop = 1'b1;
          tx_next  = TX_STROBE;
        end
      end
      TX_STROBE: begin
        tx_wr_en_c = 1'b1;
        tx_next    = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (uart.tx_busy)                  tx_next = TX_WAIT_DONE;
        else if (busy_timer == TIMER_LAST) tx_next = TX_IDLE;
      end
      TX_WAIT_DONE: begin
        if (!uart.tx_busy) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // Counts cycles spent waiting for busy; parked at zero everywhere else so
  // each wait starts fresh.
  always_ff @(posedge clk_50m) begin
    if (!rst_n || tx_state != TX_WAIT_BUSY) busy_timer <= '0;
    else                                    busy_timer <= busy_timer + TIMER_ONE;
  end

  // The masked byte is captured as it leaves the buffer and held until the
  // next pop; the echo counter advances with each byte handed over.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      tx_data_q  <= '0;
      echo_count <= '0;
    end else if (fifo_pop) begin
      tx_data_q  <= fifo_dout ^ XOR_MASK;
      echo_count <= echo_count + 16'd1;
    end
  end

  // A byte is lost only when it arrives full and nothing leaves that cycle.
  always_ff @(posedge clk_50m) begin
    if (!rst_n)                                     overflow <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop)   overflow <= 1'b1;
  end

  assign uart.rx_ready_clr = rx_ready_clr_c;
  assign uart.tx_wr_en     = tx_wr_en_c;
  assign uart.tx_data      = tx_data_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_echo_responder
// Two responders (mask 8'h00 and mask 8'hFF) share identical stimulus. A
// queue-based reference model follows every acknowledged byte and every
// strobe; directed tables and sequences cover latency, timeout, overflow,
// held-ready and reset behaviour.
// ---------------------------------------------------------------------------
module tb_uart_echo_responder;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BUSY_NORMAL = 0;
  localparam int BUSY_HOLD   = 1;
  localparam int BUSY_LOW    = 2;

  logic             clk_50m = 1'b0;
  logic             rst_n   = 1'b0;
  logic             rx_ready = 1'b0;
  logic [7:0]       rx_data  = 8'h00;
  logic             tx_busy_normal = 1'b0;
  logic             busy_w;
  int               busy_mode = BUSY_NORMAL;

  logic [CNT_W-1:0] fifo_count0, fifo_count1;
  logic             overflow0, overflow1;
  logic [15:0]      echo_count0, echo_count1;

  int checks = 0;
  int errors = 0;

  always #10 clk_50m = ~clk_50m;

  uart_echo_responder_if if0 ();
  uart_echo_responder_if if1 ();

  assign busy_w = (busy_mode == BUSY_HOLD) ? 1'b1 :
                  (busy_mode == BUSY_LOW)  ? 1'b0 : tx_busy_normal;

  assign if0.rx_ready = rx_ready;
  assign if0.rx_data  = rx_data;
  assign if0.tx_busy  = busy_w;
  assign if1.rx_ready = rx_ready;
  assign if1.rx_data  = rx_data;
  assign if1.tx_busy  = busy_w;

  uart_echo_responder #(.FIFO_DEPTH(DEPTH), .XOR_MASK(8'h00), .BUSY_TIMEOUT(4)) dut0 (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .uart       (if0.slave),
    .fifo_count (fifo_count0),
    .overflow   (overflow0),
    .echo_count (echo_count0)
  );

  uart_echo_responder #(.FIFO_DEPTH(DEPTH), .XOR_MASK(8'hFF), .BUSY_TIMEOUT(4)) dut1 (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .uart       (if1.slave),
    .fifo_count (fifo_count1),
    .overflow   (overflow1),
    .echo_count (echo_count1)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter stand-in: after a strobe, busy rises after a random delay
  // (sometimes too late, exercising the timeout) and stays up a while.
  int busy_delay, busy_hold;
  initial begin
    forever begin
      @(negedge clk_50m);
      if (if0.tx_wr_en) begin
        busy_delay = $urandom_range(0, 5);
        busy_hold  = $urandom_range(1, 6);
        repeat (busy_delay) @(negedge clk_50m);
        tx_busy_normal = 1'b1;
        repeat (busy_hold) @(negedge clk_50m);
        tx_busy_normal = 1'b0;
      end
    end
  end

  // Reference model: a queue of accepted bytes, a sticky drop flag and a
  // hand-off counter, updated from the acknowledge and strobe events.
  logic [7:0]  model_q[$];
  logic        model_ovf = 1'b0;
  logic [15:0] model_echo = 16'd0;
  logic [7:0]  last_tx0 = 8'h00, last_tx1 = 8'h00, exp_b;
  logic        prev_clr = 1'b0, prev_wr = 1'b0, pushed, popped;
  int          strobe_cnt = 0, clr_cnt = 0, cyc = 0;
  int          last_strobe_cyc = 0, prev_strobe_cyc = 0;

  always @(posedge clk_50m) begin
    #1;
    cyc++;
    if (!rst_n) begin
      model_q.delete();
      model_ovf  = 1'b0;
      model_echo = 16'd0;
      last_tx0   = 8'h00;
      last_tx1   = 8'h00;
      prev_clr   = 1'b0;
      prev_wr    = 1'b0;
      check_output("rst_clr0",   if0.rx_ready_clr, 0);
      check_output("rst_wr0",    if0.tx_wr_en, 0);
      check_output("rst_data0",  if0.tx_data, 0);
      check_output("rst_data1",  if1.tx_data, 0);
      check_output("rst_count0", fifo_count0, 0);
      check_output("rst_ovf0",   overflow0, 0);
      check_output("rst_echo0",  echo_count0, 0);
      check_output("rst_echo1",  echo_count1, 0);
    end else begin
      pushed = if0.rx_ready_clr;
      popped = if0.tx_wr_en;
      check_output("clr_pair", if1.rx_ready_clr, pushed);
      check_output("wr_pair",  if1.tx_wr_en, popped);
      if (pushed) check_output("clr_not_consecutive", prev_clr, 0);
      if (popped) check_output("wr_not_consecutive", prev_wr, 0);
      if (popped) begin
        strobe_cnt++;
        prev_strobe_cyc = last_strobe_cyc;
        last_strobe_cyc = cyc;
        if (model_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL pop_empty: strobe seen, got 1 expected 0 queued bytes");
        end else begin
          exp_b = model_q.pop_front();
          last_tx0 = exp_b;
          last_tx1 = exp_b ^ 8'hFF;
          model_echo = model_echo + 16'd1;
        end
      end
      if (pushed) begin
        clr_cnt++;
        if (model_q.size() >= DEPTH) model_ovf = 1'b1;
        else                         model_q.push_back(rx_data);
      end
      check_output("tx_data0",   if0.tx_data, last_tx0);
      check_output("tx_data1",   if1.tx_data, last_tx1);
      check_output("fifo_count0", fifo_count0, model_q.size());
      check_output("fifo_count1", fifo_count1, model_q.size());
      check_output("overflow0",  overflow0, model_ovf);
      check_output("overflow1",  overflow1, model_ovf);
      check_output("echo_count0", echo_count0, model_echo);
      check_output("echo_count1", echo_count1, model_echo);
      prev_clr = pushed;
      prev_wr  = popped;
    end
  end

  // Behaves like the uart receiver: present a byte, wait for the
  // acknowledge, drop ready, and leave it low long enough to be seen.
  task automatic apply_stimulus(input logic [7:0] b);
    logic seen;
    seen = 1'b0;
    @(negedge clk_50m);
    rx_data  = b;
    rx_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_50m);
      #2;
      if (if0.rx_ready_clr) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("rx_ack_seen", seen, 1);
    @(negedge clk_50m);
    rx_ready = 1'b0;
    @(negedge clk_50m);
  endtask

  task automatic wait_strobes(input int target, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (strobe_cnt >= target) break;
      @(posedge clk_50m);
      #2;
    end
    check_output("strobe_wait", (strobe_cnt >= target), 1);
  endtask

  task automatic wait_idle();
    int quiet;
    logic ok;
    quiet = 0;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_50m);
      if (fifo_count0 == 0 && !if0.tx_wr_en && !tx_busy_normal) quiet++;
      else quiet = 0;
      if (quiet >= 14) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("idle_reached", ok, 1);
  endtask

  typedef struct packed {
    logic [7:0] rx;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } vec_t;

  vec_t        vecs[4];
  int          base_s, base_c;
  logic [15:0] e0, d16;

  initial begin
    vecs[0] = '{rx: 8'h00, exp0: 8'h00, exp1: 8'hFF};
    vecs[1] = '{rx: 8'h01, exp0: 8'h01, exp1: 8'hFE};
    vecs[2] = '{rx: 8'h02, exp0: 8'h02, exp1: 8'hFD};
    vecs[3] = '{rx: 8'hC3, exp0: 8'hC3, exp1: 8'h3C};

    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Directed loopback table
    for (int i = 0; i < 4; i++) begin
      base_s = strobe_cnt;
      apply_stimulus(vecs[i].rx);
      wait_strobes(base_s + 1, 40);
      check_output("vec_tx0", if0.tx_data, vecs[i].exp0);
      check_output("vec_tx1", if1.tx_data, vecs[i].exp1);
    end
    wait_idle();
    check_output("loop_echo", echo_count0, 4);
    check_output("loop_ovf", overflow0, 0);

    // Latency from ready to acknowledge and strobe
    @(negedge clk_50m);
    rx_data  = 8'hA5;
    rx_ready = 1'b1;
    @(posedge clk_50m); #2;
    check_output("lat_clr_n", if1.rx_ready_clr, 1);
    check_output("lat_wr_n", if1.tx_wr_en, 0);
    check_output("lat_count_n", fifo_count1, 1);
    @(negedge clk_50m);
    rx_ready = 1'b0;
    @(posedge clk_50m); #2;
    check_output("lat_wr_n1", if1.tx_wr_en, 1);
    check_output("lat_clr_n1", if1.rx_ready_clr, 0);
    check_output("lat_data1", if1.tx_data, 8'h5A);
    check_output("lat_data0", if0.tx_data, 8'hA5);
    @(posedge clk_50m); #2;
    check_output("lat_wr_n2", if1.tx_wr_en, 0);
    wait_idle();

    // Transmitter that never raises busy
    busy_mode = BUSY_LOW;
    base_s = strobe_cnt;
    e0 = echo_count0;
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    wait_strobes(base_s + 2, 60);
    check_output("timeout_gap", last_strobe_cyc - prev_strobe_cyc, 6);
    repeat (20) @(negedge clk_50m);
    check_output("timeout_strobes", strobe_cnt - base_s, 2);
    d16 = echo_count0 - e0;
    check_output("timeout_echo", d16, 2);
    check_output("timeout_last", if0.tx_data, 8'h22);
    busy_mode = BUSY_NORMAL;
    wait_idle();

    // Ready held high for 10 cycles
    base_s = strobe_cnt;
    base_c = clr_cnt;
    @(negedge clk_50m);
    rx_data  = 8'h3C;
    rx_ready = 1'b1;
    repeat (10) @(negedge clk_50m);
    rx_ready = 1'b0;
    repeat (15) @(negedge clk_50m);
    check_output("hold_clr_pulses", clr_cnt - base_c, 1);
    wait_strobes(base_s + 1, 40);
    wait_idle();
    check_output("hold_strobes", strobe_cnt - base_s, 1);
    check_output("hold_data", if0.tx_data, 8'h3C);

    // Overflow with the transmitter held busy
    busy_mode = BUSY_HOLD;
    base_s = strobe_cnt;
    base_c = clr_cnt;
    for (int i = 0; i < 5; i++) apply_stimulus(8'h40 + 8'(i));
    repeat (3) @(negedge clk_50m);
    check_output("ovf_count", fifo_count0, 4);
    check_output("ovf_flag", overflow0, 1);
    check_output("ovf_clr_pulses", clr_cnt - base_c, 5);
    check_output("ovf_no_strobe", strobe_cnt - base_s, 0);
    busy_mode = BUSY_NORMAL;
    wait_strobes(base_s + 4, 200);
    wait_idle();
    check_output("ovf_echoed", strobe_cnt - base_s, 4);
    check_output("ovf_last", if0.tx_data, 8'h43);
    check_output("ovf_sticky", overflow0, 1);

    // Randomized traffic checked by the model
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(8'($urandom));
      repeat ($urandom_range(0, 4)) @(negedge clk_50m);
    end
    wait_idle();
    check_output("rand_drained", fifo_count0, 0);
    check_output("rand_echo", echo_count0, model_echo);

    // Reset with bytes buffered
    busy_mode = BUSY_HOLD;
    for (int i = 0; i < 3; i++) apply_stimulus(8'h70 + 8'(i));
    repeat (2) @(negedge clk_50m);
    check_output("rstmid_count", fifo_count0, 3);
    @(negedge clk_50m);
    rst_n = 1'b0;
    @(posedge clk_50m); #2;
    check_output("rstmid_count0", fifo_count0, 0);
    check_output("rstmid_ovf", overflow0, 0);
    check_output("rstmid_echo", echo_count0, 0);
    check_output("rstmid_data1", if1.tx_data, 0);
    check_output("rstmid_wr", if0.tx_wr_en, 0);
    check_output("rstmid_clr", if0.rx_ready_clr, 0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    busy_mode = BUSY_NORMAL;
    base_s = strobe_cnt;
    repeat (30) @(negedge clk_50m);
    check_output("rstmid_no_echo", strobe_cnt - base_s, 0);
    check_output("rstmid_echo_after", echo_count0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(20 * 60000);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
